// File: rtl/vblank_mem_arbiter.sv
// Single-port RAM arbiter: the display reader owns the port during active video,
// and N_REQ update requesters share it round-robin in bursts inside vertical blank.
module vblank_mem_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 12,
  parameter int MAX_BURST    = 8,
  parameter int WIN_END_LINE = 626
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [10:0]              vcount,
  input  logic                     vblnk,
  input  logic                     disp_en,
  input  logic [ADDR_W-1:0]        disp_addr,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     win_open,
  output logic                     overrun
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {DISPLAY, ARB, GRANT} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]  cur, cur_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic              mem_en_nxt, mem_we_nxt, overrun_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              window;
  logic              beat, release_now;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  assign window = vblnk && (vcount <= 11'(WIN_END_LINE));

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
  logic             hit_hi, hit_any;
  logic [IDX_W-1:0] pick_hi, pick_any, pick;

  always_comb begin
    hit_hi   = 1'b0;
    hit_any  = 1'b0;
    pick_hi  = '0;
    pick_any = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_any  = 1'b1;
        pick_any = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          hit_hi  = 1'b1;
          pick_hi = IDX_W'(i);
        end
      end
    end
    pick = hit_hi ? pick_hi : pick_any;
  end

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    cur_nxt       = cur;
    rr_ptr_nxt    = rr_ptr;
    beat_cnt_nxt  = beat_cnt;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    overrun_nxt   = overrun | (win_open & ~window & (|req));
    beat          = 1'b0;
    release_now   = 1'b0;

    case (state)
      DISPLAY: begin
        gnt_nxt      = '0;
        mem_en_nxt   = disp_en;
        mem_addr_nxt = disp_addr;
        if (window) state_nxt = ARB;
      end
      ARB: begin
        gnt_nxt = '0;
        if (!window) begin
          state_nxt = DISPLAY;
        end else if (hit_any) begin
          gnt_nxt      = N_REQ'(1) << pick;
          cur_nxt      = pick;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end
      GRANT: begin
        // A beat still goes out on the cycle the window closes.
        beat = req[cur];
        if (beat) begin
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = req_we[cur];
          mem_addr_nxt  = addr_arr[cur];
          mem_wdata_nxt = wdata_arr[cur];
          beat_cnt_nxt  = beat_cnt + 1'b1;
        end
        release_now = !beat || (beat_cnt == LAST_BEAT) || !window;
        if (release_now) begin
          gnt_nxt    = '0;
          rr_ptr_nxt = (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
          state_nxt  = window ? ARB : DISPLAY;
        end
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = DISPLAY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DISPLAY;
      gnt       <= '0;
      cur       <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      win_open  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      cur       <= cur_nxt;
      rr_ptr    <= rr_ptr_nxt;
      beat_cnt  <= beat_cnt_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      win_open  <= window;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_vblank_mem_arbiter.sv
// Scoreboard bench for vblank_mem_arbiter: random requesters over a compressed
// frame, expected outputs produced by a behavioural model and checked by a monitor.
module tb_vblank_mem_arbiter;

  localparam int N       = 4;
  localparam int AW      = 16;
  localparam int DW      = 12;
  localparam int MAXB    = 8;
  localparam int WIN_END = 626;
  localparam int LINE    = 6;
  localparam int FRAME   = 38 * LINE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [10:0]     vcount = '0;
  logic            vblnk = 1'b0;
  logic            disp_en = 1'b0;
  logic [AW-1:0]   disp_addr = '0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt;
  logic            mem_en, mem_we, win_open, overrun;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;

  vblank_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB),
                       .WIN_END_LINE(WIN_END)) dut (
    .clk(clk), .rst_n(rst_n), .vcount(vcount), .vblnk(vblnk),
    .disp_en(disp_en), .disp_addr(disp_addr), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .win_open(win_open), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          en, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          win, ovr;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Model of the arbitration rules: who owns the port, burst progress, pointer.
  bit            m_live;
  int            m_owner, m_beats, m_ptr;
  bit            m_win_q, m_ovr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            vc = 590;
  int            lc = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic modelReset();
    m_live = 0; m_owner = -1; m_beats = 0; m_ptr = 0;
    m_win_q = 0; m_ovr = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic modelStep(output exp_t e);
    bit win;
    win = vblnk && (int'(vcount) <= WIN_END);
    e.win = win;
    e.ovr = m_ovr || (m_win_q && !win && (req != 0));
    e.gnt = '0; e.en = 0; e.we = 0; e.addr = m_addr; e.wdata = m_wdata;
    if (!m_live) begin
      e.en = disp_en;
      e.addr = disp_addr;
      if (win) m_live = 1;
    end else if (m_owner < 0) begin
      if (!win) m_live = 0;
      else begin
        for (int k = 0; k < N; k++) begin
          int c = (m_ptr + k) % N;
          if (req[c]) begin
            m_owner = c;
            m_beats = 0;
            break;
          end
        end
        if (m_owner >= 0) e.gnt = N'(1 << m_owner);
      end
    end else begin
      int o = m_owner;
      bit took = req[o];
      if (took) begin
        e.en = 1;
        e.we = req_we[o];
        e.addr = req_addr[o*AW +: AW];
        e.wdata = req_wdata[o*DW +: DW];
        m_beats++;
      end
      if (!took || m_beats == MAXB || !win) begin
        m_ptr = (o + 1) % N;
        m_owner = -1;
        if (!win) m_live = 0;
      end else begin
        e.gnt = N'(1 << o);
      end
    end
    m_win_q = win;
    m_ovr = e.ovr;
    m_addr = e.addr;
    m_wdata = e.wdata;
  endtask

  // mode 0: no requests, 1: all requesting, 2: random walk, 3: fixed display + req 0101
  task automatic applyStimulus(input int mode);
    exp_t e;
    @(negedge clk);
    vcount = 11'(vc);
    vblnk = (vc >= 600);
    case (mode)
      0: req = '0;
      1: req = '1;
      3: req = 4'b0101;
      default: begin
        for (int i = 0; i < N; i++) begin
          if (req[i]) req[i] = ($urandom_range(0, 4) != 0);
          else        req[i] = ($urandom_range(0, 2) == 0);
        end
      end
    endcase
    disp_en   = (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
    disp_addr = (mode == 3) ? 16'h1234 : AW'($urandom);
    req_we    = N'($urandom);
    req_addr  = {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)};
    req_wdata = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
    modelStep(e);
    sb.push_back(e);
    if (++lc == LINE) begin
      lc = 0;
      vc = (vc == 627) ? 590 : vc + 1;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("gnt", 32'(gnt), 32'(e.gnt));
    cmp("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    cmp("mem_en", 32'(mem_en), 32'(e.en));
    cmp("mem_we", 32'(mem_we), 32'(e.we));
    cmp("mem_addr", 32'(mem_addr), 32'(e.addr));
    cmp("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
    cmp("win_open", 32'(win_open), 32'(e.win));
    cmp("overrun", 32'(overrun), 32'(e.ovr));
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, "_gnt"}, 32'(gnt), 0);
    cmp({tag, "_mem_en"}, 32'(mem_en), 0);
    cmp({tag, "_mem_we"}, 32'(mem_we), 0);
    cmp({tag, "_mem_addr"}, 32'(mem_addr), 0);
    cmp({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    cmp({tag, "_win_open"}, 32'(win_open), 0);
    cmp({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkReset("midreset");
    modelReset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: every registered output update is checked against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int budget;
    modelReset();
    #1;
    checkReset("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    repeat (FRAME) applyStimulus(0);
    repeat (FRAME) applyStimulus(3);
    repeat (FRAME) applyStimulus(1);
    repeat (4 * FRAME) applyStimulus(2);

    budget = 0;
    while (!(m_owner >= 0 && m_live) && budget < 2 * FRAME) begin
      applyStimulus(1);
      budget++;
    end
    cmp("reach_grant", 32'(m_owner >= 0), 32'd1);
    doReset();

    repeat (2 * FRAME) applyStimulus(2);
    repeat (FRAME) applyStimulus(1);

    @(posedge clk);
    #2;
    cmp("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
